// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: the polynomial both generator and checker agree on,
// the checker state type and the feedback helper.
package prbs_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  // x^4 + x^3 + 1: feedback from the two oldest bits of a left-shifting register
  localparam int                    PRBS_WIDTH    = 4;
  localparam logic [PRBS_WIDTH-1:0] PRBS_TAP_MASK = 4'b1100;

  function automatic logic next_bit(input logic [31:0] state, input logic [31:0] mask);
    return ^(state & mask);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a clear beats a same-cycle increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_value
);

  logic [CNT_W-1:0] r_value;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_value <= '0;
    end else if (i_inc && (r_value != '1)) begin
      r_value <= r_value + CNT_W'(1);
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: seeds its predictor from the incoming stream, then flags
// every bit that disagrees with the prediction and drops lock on error bursts.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH      = PRBS_WIDTH,
  parameter logic [WIDTH-1:0] TAP_MASK   = PRBS_TAP_MASK,
  parameter int               ERR_WIN    = 16,
  parameter int               ERR_THRESH = 4,
  parameter int               CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_din,
  input  logic             i_din_valid,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [CNT_W-1:0] o_err_count,
  output logic [CNT_W-1:0] o_bit_count
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int WIN_W  = $clog2(ERR_WIN + 1);
  localparam int WERR_W = $clog2(ERR_THRESH + 1);

  prbs_state_t       r_state;
  logic [FILL_W-1:0] r_fill;
  logic [WIDTH-1:0]  r_lfsr;
  logic [WIN_W-1:0]  r_win_bits;
  logic [WERR_W-1:0] r_win_err;
  logic              r_err_pulse;

  logic              w_is_locked;
  logic              w_exp;
  logic              w_mismatch;
  logic              w_check;
  logic [WIDTH-1:0]  w_seed_lfsr;
  logic              w_fill_done;
  logic              w_lose_lock;
  logic              w_win_end;

  assign w_is_locked = (r_state == LOCKED);
  assign w_exp       = next_bit(32'(r_lfsr), 32'(TAP_MASK));
  assign w_check     = i_din_valid && w_is_locked;
  assign w_mismatch  = w_check && (i_din != w_exp);
  assign w_seed_lfsr = {r_lfsr[WIDTH-2:0], i_din};
  assign w_fill_done = (r_fill == FILL_W'(WIDTH - 1));
  assign w_lose_lock = w_mismatch && (r_win_err == WERR_W'(ERR_THRESH - 1));
  assign w_win_end   = (r_win_bits == WIN_W'(ERR_WIN - 1));

  // Locked: the predictor free-runs on its own output so a bad bit costs one error
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= SEARCH;
      r_fill      <= '0;
      r_lfsr      <= '0;
      r_win_bits  <= '0;
      r_win_err   <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (i_din_valid) begin
        if (!w_is_locked) begin
          r_lfsr <= w_seed_lfsr;
          if (w_fill_done) begin
            r_fill <= '0;
            if (w_seed_lfsr != '0) begin
              r_state    <= LOCKED;
              r_win_bits <= '0;
              r_win_err  <= '0;
            end
          end else begin
            r_fill <= r_fill + FILL_W'(1);
          end
        end else begin
          r_lfsr      <= {r_lfsr[WIDTH-2:0], w_exp};
          r_err_pulse <= w_mismatch;
          if (w_lose_lock) begin
            r_state    <= SEARCH;
            r_fill     <= '0;
            r_win_bits <= '0;
            r_win_err  <= '0;
          end else if (w_win_end) begin
            r_win_bits <= '0;
            r_win_err  <= '0;
          end else begin
            r_win_bits <= r_win_bits + WIN_W'(1);
            if (w_mismatch) begin
              r_win_err <= r_win_err + WERR_W'(1);
            end
          end
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_count (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_clr),
    .i_inc   (w_mismatch),
    .o_value (o_err_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bit_count (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_clr),
    .i_inc   (w_check),
    .o_value (o_bit_count)
  );

  assign o_locked    = w_is_locked;
  assign o_err_pulse = r_err_pulse;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed phases plus randomized gating, checked against
// a time-domain recurrence model (b[n] = b[n-3] ^ b[n-4]) of the PRBS stream.
module tb_prbs_checker;

  localparam int CNT_W   = 16;
  localparam int MAX_CNT = (1 << CNT_W) - 1;
  localparam int WIN     = 16;
  localparam int THRESH  = 4;

  logic             clk = 1'b0;
  logic             reset, clr, din, dinValid;
  logic             locked, errPulse;
  logic [CNT_W-1:0] errCount, bitCount;

  logic             satReset, satClr, satDin, satValid;
  logic             satLocked, satErrPulse;
  logic [3:0]       satErrCount, satBitCount;

  int compareCount = 0;
  int failCount    = 0;

  bit pattern[15] = '{0,0,1,1,0,1,0,1,1,1,1,0,0,0,1};
  int pos = 0;

  bit mLocked   = 0;
  bit mErrPulse = 0;
  int mFill     = 0;
  int mWinBits  = 0;
  int mWinErr   = 0;
  int mErrCnt   = 0;
  int mBitCnt   = 0;
  bit hist[$]   = '{0, 0, 0, 0};

  prbs_checker dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_clr       (clr),
    .i_din       (din),
    .i_din_valid (dinValid),
    .o_locked    (locked),
    .o_err_pulse (errPulse),
    .o_err_count (errCount),
    .o_bit_count (bitCount)
  );

  prbs_checker #(.CNT_W(4), .ERR_THRESH(17)) dutSat (
    .i_clk       (clk),
    .i_reset     (satReset),
    .i_clr       (satClr),
    .i_din       (satDin),
    .i_din_valid (satValid),
    .o_locked    (satLocked),
    .o_err_pulse (satErrPulse),
    .o_err_count (satErrCount),
    .o_bit_count (satBitCount)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
    compareCount++;
    assert (got === want) else begin
      failCount++;
      $error("[TB] FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".locked"},   32'(locked),   32'(mLocked));
    checkValue({tag, ".errPulse"}, 32'(errPulse), 32'(mErrPulse));
    checkValue({tag, ".errCount"}, 32'(errCount), 32'(mErrCnt));
    checkValue({tag, ".bitCount"}, 32'(bitCount), 32'(mBitCnt));
  endtask

  // Reference: seed from the last four received bits, then predict with the recurrence
  task automatic modelStep(input bit v, input bit d, input bit c, input bit r);
    bit expBit;
    if (r) begin
      mLocked = 0; mFill = 0; mWinBits = 0; mWinErr = 0;
      mErrCnt = 0; mBitCnt = 0; mErrPulse = 0;
      hist = '{0, 0, 0, 0};
      return;
    end
    mErrPulse = 0;
    if (v) begin
      if (!mLocked) begin
        hist.push_back(d);
        void'(hist.pop_front());
        mFill++;
        if (mFill == 4) begin
          mFill = 0;
          if (hist[0] | hist[1] | hist[2] | hist[3]) begin
            mLocked = 1; mWinBits = 0; mWinErr = 0;
          end
        end
      end else begin
        expBit = hist[0] ^ hist[1];
        hist.push_back(expBit);
        void'(hist.pop_front());
        if (mBitCnt < MAX_CNT) mBitCnt++;
        mWinBits++;
        if (d != expBit) begin
          mErrPulse = 1;
          if (mErrCnt < MAX_CNT) mErrCnt++;
          mWinErr++;
        end
        if (mWinErr == THRESH) begin
          mLocked = 0; mFill = 0; mWinBits = 0; mWinErr = 0;
        end else if (mWinBits == WIN) begin
          mWinBits = 0; mWinErr = 0;
        end
      end
    end
    if (c) begin
      mErrCnt = 0; mBitCnt = 0;
    end
  endtask

  task automatic applyStimulus(input bit v, input bit d, input bit c, input bit r);
    reset = r; dinValid = v; din = d; clr = c;
    @(posedge clk);
    modelStep(v, d, c, r);
    @(negedge clk);
  endtask

  task automatic sendBit(input bit flip, input bit c, input string tag);
    bit b;
    b = pattern[pos] ^ flip;
    pos = (pos + 1) % 15;
    applyStimulus(1'b1, b, c, 1'b0);
    checkOutput(tag);
  endtask

  task automatic applySat(input bit v, input bit d, input bit r);
    satValid = v; satDin = d; satReset = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulseSeen;
    bit b;
    reset = 1'b1; clr = 1'b0; din = 1'b0; dinValid = 1'b0;
    satReset = 1'b1; satClr = 1'b0; satDin = 1'b0; satValid = 1'b0;
    @(negedge clk);

    // Reset state, with clr and din_valid also asserted
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("reset");
    checkValue("resetLocked", 32'(locked), 32'd0);
    checkValue("resetBits", 32'(bitCount), 32'd0);

    // Clean lock from the seed-0001 stream
    pos = 0;
    for (int i = 0; i < 4; i++) sendBit(1'b0, 1'b0, "seed");
    checkValue("seedLfsr", 32'(dut.r_lfsr), 32'h3);
    checkValue("seedLocked", 32'(locked), 32'd1);
    for (int i = 0; i < 30; i++) sendBit(1'b0, 1'b0, "clean");
    checkValue("cleanBits", 32'(bitCount), 32'd30);
    checkValue("cleanErrs", 32'(errCount), 32'd0);

    // Single bit error
    sendBit(1'b1, 1'b0, "oneErr");
    checkValue("oneErrPulse", 32'(errPulse), 32'd1);
    checkValue("oneErrCount", 32'(errCount), 32'd1);
    checkValue("oneErrLocked", 32'(locked), 32'd1);
    pulseSeen = 0;
    for (int i = 0; i < 15; i++) begin
      sendBit(1'b0, 1'b0, "afterErr");
      if (errPulse) pulseSeen++;
    end
    checkValue("noExtraPulse", 32'(pulseSeen), 32'd0);
    checkValue("afterErrCount", 32'(errCount), 32'd1);

    // Lock loss: align to a window start (46 locked bits so far), clear counters, 4 errors
    sendBit(1'b0, 1'b0, "align");
    sendBit(1'b0, 1'b1, "alignClr");
    checkValue("alignClrErr", 32'(errCount), 32'd0);
    for (int k = 0; k < 7; k++) sendBit((k % 2) == 0, 1'b0, "lossSeq");
    checkValue("lossLocked", 32'(locked), 32'd0);
    checkValue("lossPulse", 32'(errPulse), 32'd1);
    checkValue("lossErrCount", 32'(errCount), 32'd4);
    checkValue("lossBitCount", 32'(bitCount), 32'd7);
    for (int i = 0; i < 3; i++) sendBit(1'b0, 1'b0, "reseed");
    checkValue("reseedNotYet", 32'(locked), 32'd0);
    sendBit(1'b0, 1'b0, "reseed");
    checkValue("relocked", 32'(locked), 32'd1);
    checkValue("relockErrCount", 32'(errCount), 32'd4);

    // All-zero seed, then randomly gated stream with occasional errors
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset2");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("zeroSeed");
    end
    checkValue("zeroNoLock", 32'(locked), 32'd0);
    pos = 0;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        checkOutput("gateIdle");
      end else begin
        sendBit($urandom_range(0, 29) == 0, 1'b0, "gateBit");
      end
    end
    for (int i = 0; i < 40; i++) sendBit(1'b0, 1'b0, "gateClean");
    checkValue("gateRelock", 32'(locked), 32'd1);

    // clr together with an error bit
    sendBit(1'b1, 1'b1, "clrErr");
    checkValue("clrErrPulse", 32'(errPulse), 32'd1);
    checkValue("clrErrCount", 32'(errCount), 32'd0);
    checkValue("clrBitCount", 32'(bitCount), 32'd0);

    // Reset mid-window overrides clr and din_valid
    for (int i = 0; i < 5; i++) sendBit(1'b0, 1'b0, "preReset");
    sendBit(1'b1, 1'b0, "preResetErr");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("midReset");
    checkValue("midResetPulse", 32'(errPulse), 32'd0);
    checkValue("midResetLocked", 32'(locked), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation on the 4-bit-counter instance, which never drops lock here
    applySat(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applySat(1'b1, pattern[i], 1'b0);
    checkValue("satLock", 32'(satLocked), 32'd1);
    for (int k = 0; k < 20; k++) begin
      b = pattern[(4 + k) % 15];
      applySat(1'b1, ~b, 1'b0);
      if (k == 9) begin
        checkValue("satMidErr", 32'(satErrCount), 32'd10);
        checkValue("satMidBits", 32'(satBitCount), 32'd10);
      end
    end
    checkValue("satErr", 32'(satErrCount), 32'd15);
    checkValue("satBits", 32'(satBitCount), 32'd15);
    checkValue("satPulse", 32'(satErrPulse), 32'd1);
    checkValue("satStillLocked", 32'(satLocked), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side counterpart of the team's 4-bit LFSR/PRBS generator.
- Consumes a serial PRBS bit stream (polynomial x^4+x^3+1, period 15) one bit per qualified cycle.
- Self-synchronises by seeding from the stream, then predicts each following bit and flags mismatches.
- Keeps saturating error and bit counters; drops lock and re-seeds when errors in a window reach a threshold.

Parameters:
- WIDTH, 4, LFSR length in bits.
- TAP_MASK, 4'b1100, feedback taps; predicted bit = XOR of (state & TAP_MASK).
- ERR_WIN, 16, number of locked bits per error-evaluation window.
- ERR_THRESH, 4, window error count that forces loss of lock.
- CNT_W, 16, width of err_count and bit_count.

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- reset  input  1  synchronous, active-high; clears all state.
- clr  input  1  synchronous counter clear; clears err_count and bit_count only, lock state unaffected.
- din  input  1  serial PRBS bit.
- din_valid  input  1  din qualifier; no state changes when low, except clr.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse, registered, for each mismatching locked bit.
- err_count  output  CNT_W  saturating count of mismatches while locked.
- bit_count  output  CNT_W  saturating count of bits checked while locked.

Behaviour:
- Reset (synchronous, active-high):
  - state=SEARCH; fill=0; lfsr=0; win_bits=0; win_err=0.
  - locked=0; err_pulse=0; err_count=0; bit_count=0.
- Defaults:
  - err_pulse is 0 unless set this cycle.
  - Every action below occurs only on cycles with din_valid=1.
- SEARCH:
  - lfsr <= {lfsr[WIDTH-2:0], din}; fill increments.
  - When the WIDTH-th bit is accepted:
    - If the resulting lfsr is non-zero -> LOCKED next cycle; locked=1 from that cycle; window counters cleared.
    - If the resulting lfsr is all zero -> stay in SEARCH; fill=0; refill.
- LOCKED, per valid bit:
  - exp = ^(lfsr & TAP_MASK).
  - lfsr <= {lfsr[WIDTH-2:0], exp}. The predictor advances on its own expected bit, never on the received bit, so one bad bit produces exactly one error.
  - bit_count increments, saturating at all-ones.
  - If din != exp: err_pulse=1 next cycle; err_count increments (saturating); win_err increments.
  - win_bits increments. When it reaches ERR_WIN, win_bits=0 and win_err=0, unless the cycle also causes loss of lock.
- Loss of lock:
  - Triggered when win_err would reach ERR_THRESH on this bit.
  - Next cycle: state=SEARCH; locked=0; fill=0; window counters cleared.
  - err_pulse for that bit is still issued. err_count and bit_count are retained.
- clr:
  - Zeroes err_count and bit_count and wins over a same-cycle increment.
  - err_pulse is still produced normally.
- Reset mid-operation overrides everything, including clr and din_valid.
- Latency: one cycle from the accepted din to err_pulse, counter update and locked change.
- Non-maximal TAP_MASK values are not required to work. Verify with the default only.

Decomposition:
- Shared package prbs_pkg:
  - state enum SEARCH/LOCKED.
  - default WIDTH/TAP_MASK constants, shared with the generator so both ends agree on the polynomial.
  - a function next_bit(state, mask).
- One natural sub-module: sat_counter (CNT_W, inc, clr, value), instantiated for err_count and bit_count.

Test Plan:
- Clean lock:
  - Stimulus: after reset, feed a stream from seed 0001, bits 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1 repeated, din_valid=1.
  - Required: the first 4 bits seed lfsr=0011; locked=1 one cycle later; after 30 more bits, err_count=0 and bit_count=30.
- Single bit error:
  - Stimulus: once locked, invert one bit.
  - Required: exactly one err_pulse the following cycle; err_count=1; locked stays 1; the next 15 correct bits give no further errors.
- Lock loss:
  - Stimulus: invert 4 bits within one 16-bit window.
  - Required: locked drops the cycle after the 4th error; re-lock after 4 further clean bits; err_count=4 retained.
- All-zero seed and gating:
  - Stimulus: feed 0,0,0,0 in SEARCH, then a valid stream; toggle din_valid=0 for random cycles.
  - Required: no lock on the zero seed; lock on the next non-zero 4-bit fill; counters frozen during din_valid=0.
- clr, saturation and reset:
  - Stimulus: pulse clr together with an error bit; run with CNT_W=4 and continuous errors while forcing lock; assert reset mid-window.
  - Required: clr yields counters=0 with err_pulse=1; counters hold at 15 at saturation; reset returns all outputs to 0 in the next cycle.
